// File: rtl/half_subtractor_lane.sv
// ---------------------------------------------------------------------------
// half_subtractor_lane
// Purely combinational 1-bit half-subtractor cell computing a - b.
//
// Ports:
//   a  : minuend bit
//   b  : subtrahend bit
//   d  : difference bit (a xor b)
//   bo : borrow-out bit, set only when a = 0 and b = 1
//
// Truth table (a b | d bo):
//   0 0 | 0 0
//   0 1 | 1 1
//   1 0 | 1 0
//   1 1 | 0 0
// ---------------------------------------------------------------------------
module half_subtractor_lane (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  always_comb begin
    d  = a ^ b;
    bo = ~a & b;
  end

endmodule

// File: rtl/half_subtractor_behavioral.sv
// ---------------------------------------------------------------------------
// half_subtractor_behavioral
// Registered, lane-parallel half subtractor. Each of the WIDTH lanes computes
// A[i] - B[i] independently; results are registered with one cycle of latency
// together with a valid strobe, an any-borrow flag and a saturating count of
// accepted samples that produced at least one borrow.
//
// Parameters:
//   WIDTH : number of independent 1-bit lanes (>= 1)
//   CNT_W : width of the borrow-event counter (>= 1)
//
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset, clears every register
//   in_valid     : A/B are accepted on a rising edge when high
//   A            : minuend bits, lane i = A[i]
//   B            : subtrahend bits, lane i = B[i]
//   out_valid    : difference/borrow/borrow_any hold a fresh result
//   difference   : per-lane A xor B
//   borrow       : per-lane (not A) and B
//   borrow_any   : OR of the registered borrow vector
//   borrow_count : saturating count of accepted samples with any borrow
// ---------------------------------------------------------------------------
module half_subtractor_behavioral #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] difference,
  output logic [WIDTH-1:0] borrow,
  output logic             borrow_any,
  output logic [CNT_W-1:0] borrow_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] borrow_next;
  logic             borrow_any_next;
  logic             cnt_sat;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_subtractor_lane u_lane (
      .a  (A[i]),
      .b  (B[i]),
      .d  (diff_next[i]),
      .bo (borrow_next[i])
    );
  end

  always_comb begin
    borrow_any_next = |borrow_next;
    cnt_sat         = (borrow_count == CNT_MAX);
  end

  // Data registers only load on accepted samples, so A/B (possibly X) are
  // never observed while in_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      difference   <= '0;
      borrow       <= '0;
      borrow_any   <= 1'b0;
      borrow_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        difference <= diff_next;
        borrow     <= borrow_next;
        borrow_any <= borrow_any_next;
        if (borrow_any_next && !cnt_sat) begin
          borrow_count <= borrow_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor_behavioral.sv
// ---------------------------------------------------------------------------
// tb_half_subtractor_behavioral
// Two instances share clk/rst: u_w1 (WIDTH=1, CNT_W=2) and u_w4 (WIDTH=4,
// CNT_W=8). A reference model computes each lane as integer subtraction
// a - b: a negative result means borrow, the result mod 2 is the difference.
// ---------------------------------------------------------------------------
module tb_half_subtractor_behavioral;

  logic       clk;
  logic       rst;

  logic       v1;
  logic [0:0] a1, b1;
  logic       ov1;
  logic [0:0] d1, bo1;
  logic       any1;
  logic [1:0] cnt1;

  logic       v4;
  logic [3:0] a4, b4;
  logic       ov4;
  logic [3:0] d4, bo4;
  logic       any4;
  logic [7:0] cnt4;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic       m_ov1, m_any1;
  logic [3:0] m_d1, m_bo1;
  int         m_cnt1;
  logic       m_ov4, m_any4;
  logic [3:0] m_d4, m_bo4;
  int         m_cnt4;

  half_subtractor_behavioral #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .A(a1), .B(b1),
    .out_valid(ov1), .difference(d1), .borrow(bo1),
    .borrow_any(any1), .borrow_count(cnt1)
  );

  half_subtractor_behavioral #(.WIDTH(4), .CNT_W(8)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .A(a4), .B(b4),
    .out_valid(ov4), .difference(d4), .borrow(bo4),
    .borrow_any(any4), .borrow_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_sub(input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] d, output logic [3:0] bo);
    for (int i = 0; i < 4; i++) begin
      int r;
      r = int'(a[i]) - int'(b[i]);
      bo[i] = (r < 0);
      d[i]  = (((r + 2) % 2) == 1);
    end
  endfunction

  task automatic model_clear();
    m_ov1 = 0; m_any1 = 0; m_d1 = 0; m_bo1 = 0; m_cnt1 = 0;
    m_ov4 = 0; m_any4 = 0; m_d4 = 0; m_bo4 = 0; m_cnt4 = 0;
  endtask

  // Advance one edge, update the model from the driven inputs, compare #1 later.
  task automatic tick(input string tag);
    logic [3:0] d, bo;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      m_ov1 = v1;
      if (v1) begin
        ref_sub({3'b000, a1}, {3'b000, b1}, d, bo);
        m_d1 = d; m_bo1 = bo; m_any1 = (bo != 0);
        if (m_any1 && m_cnt1 < 3) m_cnt1++;
      end
      m_ov4 = v4;
      if (v4) begin
        ref_sub(a4, b4, d, bo);
        m_d4 = d; m_bo4 = bo; m_any4 = (bo != 0);
        if (m_any4 && m_cnt4 < 255) m_cnt4++;
      end
    end
    #1;
    checks++; if (ov1 !== m_ov1) begin errors++; $display("FAIL %s out_valid_w1 got=%b exp=%b", tag, ov1, m_ov1); end
    checks++; if (d1 !== m_d1[0:0]) begin errors++; $display("FAIL %s diff_w1 got=%b exp=%b", tag, d1, m_d1[0]); end
    checks++; if (bo1 !== m_bo1[0:0]) begin errors++; $display("FAIL %s borrow_w1 got=%b exp=%b", tag, bo1, m_bo1[0]); end
    checks++; if (any1 !== m_any1) begin errors++; $display("FAIL %s borrow_any_w1 got=%b exp=%b", tag, any1, m_any1); end
    checks++; if (cnt1 !== 2'(m_cnt1)) begin errors++; $display("FAIL %s count_w1 got=%0d exp=%0d", tag, cnt1, m_cnt1); end
    checks++; if (ov4 !== m_ov4) begin errors++; $display("FAIL %s out_valid_w4 got=%b exp=%b", tag, ov4, m_ov4); end
    checks++; if (d4 !== m_d4) begin errors++; $display("FAIL %s diff_w4 got=%b exp=%b", tag, d4, m_d4); end
    checks++; if (bo4 !== m_bo4) begin errors++; $display("FAIL %s borrow_w4 got=%b exp=%b", tag, bo4, m_bo4); end
    checks++; if (any4 !== m_any4) begin errors++; $display("FAIL %s borrow_any_w4 got=%b exp=%b", tag, any4, m_any4); end
    checks++; if (cnt4 !== 8'(m_cnt4)) begin errors++; $display("FAIL %s count_w4 got=%0d exp=%0d", tag, cnt4, m_cnt4); end
  endtask

  task automatic idle_inputs();
    v1 = 0; a1 = 0; b1 = 0;
    v4 = 0; a4 = 0; b4 = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({ov4, d4, bo4, any4, cnt4, ov1, d1, bo1, any1, cnt1} !== '0) begin
      errors++;
      $display("FAIL reset_async got w4=%b/%b/%b/%b/%0d w1=%b/%b/%b/%b/%0d exp all zero",
               ov4, d4, bo4, any4, cnt4, ov1, d1, bo1, any1, cnt1);
    end
    tick("reset_hold");
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_clear();
    #3;
    checks++;
    if ({ov4, d4, bo4, any4, cnt4, ov1, d1, bo1, any1, cnt1} !== '0) begin
      errors++;
      $display("FAIL reset_initial got w4=%b/%b/%b/%b/%0d w1=%b/%b/%b/%b/%0d exp all zero",
               ov4, d4, bo4, any4, cnt4, ov1, d1, bo1, any1, cnt1);
    end
    tick("reset_held");
    #2 rst = 1'b0;
    tick("reset_release_idle");
  endtask

  task automatic test_exhaustive_w1();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      v1 = 1'b1; a1 = ab[1]; b1 = ab[0];
      tick("exhaustive_w1");
    end
    v1 = 1'b0;
    checks++;
    if (cnt1 !== 2'd1) begin errors++; $display("FAIL exhaustive_count got=%0d exp=1", cnt1); end
  endtask

  task automatic test_directed_w4();
    v4 = 1'b1; a4 = 4'b1010; b4 = 4'b0110;
    tick("directed_1010_0110");
    checks++;
    if ({d4, bo4, any4} !== {4'b1100, 4'b0100, 1'b1}) begin
      errors++;
      $display("FAIL directed_a got diff=%b borrow=%b any=%b exp 1100/0100/1", d4, bo4, any4);
    end
    a4 = 4'b1111; b4 = 4'b1111;
    tick("directed_1111_1111");
    checks++;
    if ({d4, bo4, any4} !== 9'b0) begin
      errors++;
      $display("FAIL directed_b got diff=%b borrow=%b any=%b exp 0000/0000/0", d4, bo4, any4);
    end
    a4 = 4'b0000; b4 = 4'b1111;
    tick("directed_0000_1111");
    v4 = 1'b0;
  endtask

  task automatic test_valid_gating();
    logic [7:0] cnt_before;
    cnt_before = cnt4;
    v1 = 1'b0; v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      tick("valid_gating");
    end
    checks++;
    if (cnt4 !== cnt_before) begin errors++; $display("FAIL gating_count got=%0d exp=%0d", cnt4, cnt_before); end
  endtask

  task automatic test_saturation();
    int exp_seq[5] = '{1, 2, 3, 3, 3};
    idle_inputs();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
      tick("saturation");
      checks++;
      if (cnt1 !== 2'(exp_seq[i])) begin
        errors++;
        $display("FAIL saturation_step%0d got=%0d exp=%0d", i, cnt1, exp_seq[i]);
      end
    end
    v1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 30; i++) begin
      v1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom);
      v4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
      tick("back_to_back");
    end
    for (int i = 0; i < 40; i++) begin
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      v4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      tick("random_valid");
    end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
      v4 = 1'b1; a4 = 4'($urandom) & 4'b0111; b4 = 4'b1111;
      tick("pre_reset_stream");
    end
    do_reset();
    v1 = 1'b0; v4 = 1'b0;
    tick("post_reset_no_valid");
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    v4 = 1'b1; a4 = 4'b0011; b4 = 4'b0101;
    tick("post_reset_first");
    checks++;
    if ({ov4, d4, bo4, any4, cnt4} !== {1'b1, 4'b0110, 4'b0100, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL post_reset_result got ov=%b diff=%b borrow=%b any=%b cnt=%0d exp 1/0110/0100/1/1",
               ov4, d4, bo4, any4, cnt4);
    end
    idle_inputs();
    tick("post_reset_idle");
  endtask

  initial begin
    test_reset();
    test_exhaustive_w1();
    test_directed_w4();
    test_valid_gating();
    test_saturation();
    test_back_to_back();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
